// File: rtl/cpu_sequencer_if.sv
// Avalon-style memory bus between the sequencer (master) and the instruction/data memory (slave).
interface cpu_sequencer_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WRITEBACK state walk, bus handshake,
// instruction and load-data latches, retired-instruction counter and halt on PC == 0.
module cpu_sequencer #(
    parameter logic [2:0] RESET_STATE = 3'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            pc_addr,
    input  logic [31:0]            alu_addr,
    input  logic [31:0]            store_data,
    cpu_sequencer_if.master        bus,
    output logic [2:0]             State,
    output logic [31:0]            Instruction,
    output logic [31:0]            mem_rdata,
    output logic [31:0]            instr_count,
    output logic                   active
);

    typedef enum logic [2:0] {
        StHalt      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExec      = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic [31:0] mem_rdata_q;
    logic [31:0] instr_count_q;
    logic        active_q;

    logic [5:0]  opcode;
    logic        is_load;
    logic        is_store;
    logic        fetch_done;
    logic        load_done;

    assign opcode   = instr_q[31:26];
    assign is_load  = (opcode >= 6'h20) && (opcode <= 6'h26);
    assign is_store = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2A) ||
                      (opcode == 6'h2B) || (opcode == 6'h2E);

    // Latch enables mirror the strobe conditions so a stalled or suppressed transfer never writes.
    assign fetch_done = (state_q == StFetch) && (pc_addr != 32'd0) && !bus.waitrequest;
    assign load_done  = (state_q == StMem) && !is_store && !bus.waitrequest;

    always_comb begin
        state_d       = state_q;
        bus.address   = 32'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'd0;
        case (state_q)
            StFetch: begin
                if (pc_addr == 32'd0) begin
                    state_d = StHalt;
                end else begin
                    bus.read    = 1'b1;
                    bus.address = pc_addr;
                    if (!bus.waitrequest) begin
                        state_d = StDecode;
                    end
                end
            end
            StDecode: state_d = StExec;
            StExec:   state_d = (is_load || is_store) ? StMem : StWriteback;
            StMem: begin
                bus.address = alu_addr;
                if (is_store) begin
                    bus.write     = 1'b1;
                    bus.writedata = store_data;
                end else begin
                    bus.read = 1'b1;
                end
                if (!bus.waitrequest) begin
                    state_d = StWriteback;
                end
            end
            StWriteback: state_d = StFetch;
            StHalt:      state_d = StHalt;
            default:     state_d = StFetch;
        endcase
        // The state register already holds FETCH during reset; keep the bus quiet until release.
        if (!reset) begin
            bus.address   = 32'd0;
            bus.read      = 1'b0;
            bus.write     = 1'b0;
            bus.writedata = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= state_e'(RESET_STATE);
            instr_q       <= 32'd0;
            mem_rdata_q   <= 32'd0;
            instr_count_q <= 32'd0;
            active_q      <= 1'b1;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d != StHalt);
            if (fetch_done) begin
                instr_q <= bus.readdata;
            end
            if (load_done) begin
                mem_rdata_q <= bus.readdata;
            end
            if (state_q == StWriteback) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
        end
    end

    assign State       = state_q;
    assign Instruction = instr_q;
    assign mem_rdata   = mem_rdata_q;
    assign instr_count = instr_count_q;
    assign active      = active_q;

endmodule
